bcd_mod100_seq_ctrl: RTL and testbench

// Run-control sequencer for a two-decade (units/tens) BCD up-counter.

---
 rtl/bcd_mod100_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_bcd_mod100_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod100_seq_ctrl.sv
// Run-control sequencer for a two-decade (tens/units) BCD up-counter.
// Accepts clear/load/stop/start commands, steps the decade chain once per
// clock while running, and flags terminal wrap, completion and rejected loads.
module bcd_mod100_seq_ctrl #(
  parameter logic [3:0] MAX_TENS    = 4'd9,
  parameter logic [3:0] MAX_UNITS   = 4'd9,
  parameter bit         AUTO_RELOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       tc,
  output logic       done,
  output logic       busy,
  output logic       load_err
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 2 * DIGIT_W;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
  localparam logic [COUNT_W-1:0] TERMINAL  = {MAX_TENS, MAX_UNITS};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DIGIT_W-1:0] units_nxt;
  logic [DIGIT_W-1:0] tens_nxt;
  logic               tc_nxt;
  logic               done_nxt;
  logic               busy_nxt;
  logic               load_err_nxt;

  logic               at_terminal;
  logic               load_ok;
  logic               load_window;

  // Count sits on the programmed terminal value
  assign at_terminal = ({tens, units} == TERMINAL);

  // Load value must be legal BCD and not beyond the terminal count
  assign load_ok = (load_val[7:4] <= DIGIT_MAX) &&
                   (load_val[3:0] <= DIGIT_MAX) &&
                   (load_val <= TERMINAL);

  // Loads only act while the counter is parked
  assign load_window = (state == IDLE) || (state == PAUSE);

  // State, count and flag registers; every output comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      units    <= '0;
      tens     <= '0;
      tc       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      units    <= units_nxt;
      tens     <= tens_nxt;
      tc       <= tc_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      load_err <= load_err_nxt;
    end
  end

  // Command decode (clr > load > stop > start), BCD increment and terminal handling
  always_comb begin
    state_nxt    = state;
    units_nxt    = units;
    tens_nxt     = tens;
    tc_nxt       = 1'b0;
    load_err_nxt = 1'b0;

    if (clr) begin
      state_nxt = IDLE;
      units_nxt = '0;
      tens_nxt  = '0;
    end else if (load && load_window) begin
      if (load_ok) begin
        tens_nxt  = load_val[7:4];
        units_nxt = load_val[3:0];
      end else begin
        load_err_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (start && !stop) begin
            state_nxt = RUN;
          end
        end
        DONE: begin
          if (start && !stop) begin
            state_nxt = RUN;
            units_nxt = '0;
            tens_nxt  = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else if (at_terminal) begin
            if (AUTO_RELOAD) begin
              units_nxt = '0;
              tens_nxt  = '0;
              tc_nxt    = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end else if (units == DIGIT_MAX) begin
            units_nxt = '0;
            tens_nxt  = (tens == DIGIT_MAX) ? '0 : tens + DIGIT_W'(1);
          end else begin
            units_nxt = units + DIGIT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_bcd_mod100_seq_ctrl.sv
// Self-checking bench for bcd_mod100_seq_ctrl: three instances (default 99/auto
// reload, 25/stop-at-terminal, 00/auto reload) share one command stream and are
// scored against a decimal-count reference model through an expected-value queue.
module tb_bcd_mod100_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clr;
  logic       load;
  logic [7:0] load_val;

  logic [3:0] un0, tn0, un1, tn1, un2, tn2;
  logic       tc0, dn0, bs0, le0;
  logic       tc1, dn1, bs1, le1;
  logic       tc2, dn2, bs2, le2;
  logic [11:0] ob0, ob1, ob2;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model state: 0 idle, 1 run, 2 pause, 3 done
  int m_st  [3];
  int m_cnt [3];
  bit m_tc  [3];
  bit m_le  [3];
  int m_term[3] = '{99, 25, 0};
  bit m_ar  [3] = '{1'b1, 1'b0, 1'b1};

  logic [11:0] exp_q[$];

  bcd_mod100_seq_ctrl #(.MAX_TENS(4'd9), .MAX_UNITS(4'd9), .AUTO_RELOAD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val), .units(un0), .tens(tn0), .tc(tc0), .done(dn0),
    .busy(bs0), .load_err(le0));

  bcd_mod100_seq_ctrl #(.MAX_TENS(4'd2), .MAX_UNITS(4'd5), .AUTO_RELOAD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val), .units(un1), .tens(tn1), .tc(tc1), .done(dn1),
    .busy(bs1), .load_err(le1));

  bcd_mod100_seq_ctrl #(.MAX_TENS(4'd0), .MAX_UNITS(4'd0), .AUTO_RELOAD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val), .units(un2), .tens(tn2), .tc(tc2), .done(dn2),
    .busy(bs2), .load_err(le2));

  // Observed vector layout: {tens, units, tc, done, busy, load_err}
  assign ob0 = {tn0, un0, tc0, dn0, bs0, le0};
  assign ob1 = {tn1, un1, tc1, dn1, bs1, le1};
  assign ob2 = {tn2, un2, tc2, dn2, bs2, le2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] obs(input int i);
    case (i)
      0:       return ob0;
      1:       return ob1;
      default: return ob2;
    endcase
  endfunction

  function automatic logic [11:0] model_vec(input int i);
    return {4'(m_cnt[i] / 10), 4'(m_cnt[i] % 10), m_tc[i],
            (m_st[i] == 3), (m_st[i] == 1), m_le[i]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_tc[i] = 1'b0; m_le[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input bit st, input bit sp,
                                     input bit cl, input bit ld, input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    m_tc[i] = 1'b0;
    m_le[i] = 1'b0;
    if (cl) begin
      m_st[i] = 0;
      m_cnt[i] = 0;
    end else if (ld && (m_st[i] == 0 || m_st[i] == 2)) begin
      if (hi <= 9 && lo <= 9 && (hi * 10 + lo) <= m_term[i]) m_cnt[i] = hi * 10 + lo;
      else m_le[i] = 1'b1;
    end else if (m_st[i] == 1) begin
      if (sp) m_st[i] = 2;
      else if (m_cnt[i] == m_term[i]) begin
        if (m_ar[i]) begin m_cnt[i] = 0; m_tc[i] = 1'b1; end
        else m_st[i] = 3;
      end else m_cnt[i] = m_cnt[i] + 1;
    end else if (st && !sp) begin
      if (m_st[i] == 3) m_cnt[i] = 0;
      m_st[i] = 1;
    end
  endfunction

  // Drive one cycle of commands, queue the model's prediction, score after the edge
  task automatic step(input bit st, input bit sp, input bit cl, input bit ld,
                      input logic [7:0] lv);
    start = st; stop = sp; clr = cl; load = ld; load_val = lv;
    for (int i = 0; i < 3; i++) begin
      model_step(i, st, sp, cl, ld, lv);
      exp_q.push_back(model_vec(i));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cyc%0d dut%0d", cyc, i), obs(i), exp_q.pop_front());
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("reset dut%0d", i), obs(i), 12'h000);
    rst = 1'b0;

    // Full 00..99 sweep and wrap on the default instance
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(100);
    check("t1_wrap_tc", ob0, 12'h00A);
    check("t4_hold_25", ob1, 12'h254);

    // Run to 37, pause three clocks, resume
    idle(37);
    check("t2_at_37", ob0, 12'h372);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t2_paused", ob0, 12'h370);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_resume_hold", ob0, 12'h372);
    idle(1);
    check("t2_resume_38", ob0, 12'h382);

    // Loads while paused: valid, bad nibble, boundary values
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h45);
    check("t3_load_45", ob0, 12'h450);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h4A);
    check("t3_load_err", ob0, 12'h451);
    idle(1);
    check("t3_err_pulse", ob0, 12'h450);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Stop-at-terminal instance: reach DONE, restart from DONE
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(30);
    check("t4_done_25", ob1, 12'h254);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    check("t4_load_in_done", ob1, 12'h254);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_restart_00", ob1, 12'h002);
    idle(1);
    check("t4_restart_01", ob1, 12'h012);

    // start+stop in IDLE, clr+load together
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t5_start_stop_idle", ob0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    check("t5_clr_load", ob0, 12'h000);

    // Asynchronous reset while running at 58
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(58);
    check("t6_at_58", ob0, 12'h582);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("t6_async_rst dut%0d", i), obs(i), 12'h000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    check("t6_idle_after_rst", ob0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(1);
    check("t6_first_inc", ob0, 12'h012);

    // Random command soup
    for (int k = 0; k < 400; k++) begin
      bit         r_st;
      bit         r_sp;
      bit         r_cl;
      bit         r_ld;
      logic [7:0] r_v;
      r_st = ($urandom_range(0, 9) < 3);
      r_sp = ($urandom_range(0, 19) == 0);
      r_cl = ($urandom_range(0, 49) == 0);
      r_ld = ($urandom_range(0, 14) == 0);
      r_v  = 8'($urandom_range(0, 255));
      step(r_st, r_sp, r_cl, r_ld, r_v);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
